rvfi_retire_serializer: RTL and testbench
=========================================

Name: rvfi_retire_serializer

Overview:
- Producer side of the RVFI retirement trace: collects retire records from a core that completes instructions out of order.
- Re-orders them by instruction order number and drives in-order RVFI packets (valid/order/insn/trap/halt) on NRET channels.
- Sits between core writeback and the RVFI checkers/monitors.
- Enforces halt semantics: after a halted instruction retires, nothing further is emitted.

Parameters:
- NRET, 1: number of RVFI retire channels emitted per cycle.
- ILEN, 32: instruction width in bits.
- DEPTH, 8: reorder window size in records; power of two, at least 2.

Ports:
- clock  input  1  sole clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  retire record offered.
- in_ready  output  1  record accepted when in_valid && in_ready at posedge.
- in_order  input  64  instruction order number of the offered record.
- in_insn  input  ILEN  instruction word.
- in_trap  input  1  instruction trapped.
- in_halt  input  1  instruction is the last one; core halts after it.
- rvfi_valid  output  NRET  per-channel retire valid.
- rvfi_order  output  NRET*64  per-channel order; channel c occupies bits [64c+63:64c].
- rvfi_insn  output  NRET*ILEN  per-channel instruction word.
- rvfi_trap  output  NRET  per-channel trap flag.
- rvfi_halt  output  NRET  per-channel halt flag.
- pending  output  $clog2(DEPTH)+1  number of occupied buffer slots.
- halted  output  1  high once a halt record has been emitted.

Behaviour:
- Storage: DEPTH slots indexed by in_order mod DEPTH, each holding occupied, insn, trap and halt. Register head (64 bit) holds the next order number to emit.
- in_ready is combinational and equals all of:
  - !reset;
  - state == RUN;
  - (in_order - head) < DEPTH, computed as unsigned 64-bit subtraction;
  - slot[in_order mod DEPTH] unoccupied.
- Accept: on posedge with in_valid && in_ready, the slot is written and marked occupied. A record with in_order < head wraps to a large difference and is never accepted; the producer stalls.
- Emit, each posedge in state RUN:
  - k = number of consecutive occupied slots starting at head, capped at NRET.
  - k is further truncated after the first slot with halt=1; that slot is included.
  - Channels 0..k-1 are loaded with head..head+k-1; channels k..NRET-1 get valid=0 and all fields 0.
  - Emitted slots are cleared; head advances by k.
- Latency:
  - A record accepted at posedge N is eligible at posedge N+1 and is visible on rvfi_* after posedge N+1, i.e. minimum one cycle of buffering.
  - All rvfi_* outputs are registered.
  - rvfi_valid is asserted for exactly one cycle per emitted record.
- Emission uses slot state as it was before the current edge. A slot freed at edge N can be refilled from edge N+1 onward; in_ready is evaluated against the pre-edge head, so order head+DEPTH is not accepted in the cycle head advances.
- Simultaneous accept and emit of different slots in one cycle is legal. pending = occupied count after both updates.
- State machine:
  - RUN -> HALTED on the edge that emits a record with halt=1.
  - HALTED is absorbing until reset: no emission, in_ready=0, buffered slots are retained (pending frozen), halted=1.
  - rvfi_valid is 0 from the cycle after the halt packet onward.
- Channel order: lower channels always carry lower order numbers; the valid channels form a contiguous prefix.
- Reset:
  - head=0, all slots unoccupied, state RUN;
  - rvfi_valid=0 and rvfi_order/insn/trap/halt=0 on every channel;
  - pending=0, halted=0.
  - Reset mid-operation discards all buffered records, including any accept or emit on the same edge (reset has priority).
- Order arithmetic is modulo 2^64. Wrap at 2^64 is not required to be exercised.

Test Plan:
- In-order stream, NRET=1: accept orders 0,1,2 on consecutive edges with insn 0x13,0x93,0x113 -> rvfi_valid high for three consecutive cycles starting one cycle after the first accept; orders 0,1,2 with matching insn.
- Out-of-order arrival, DEPTH=8: accept 2, then 1, then 0 -> nothing emitted until 0 is buffered; then orders 0,1,2 on consecutive cycles, pending goes 3->2->1->0.
- Window limit: head=0, offer order 8 -> in_ready=0; offer 7 -> accepted. Offer 3 twice -> second offer gets in_ready=0.
- Halt: buffer 0,1(halt=1),2 with NRET=2 -> cycle 1 emits channels 0/1 = orders 0/1 with rvfi_halt[1]=1; halted=1; order 2 is never emitted, pending=1, and in_ready stays 0 for 20 cycles.
- Multi-channel truncation, NRET=2: slots 0 and 2 occupied -> only channel 0 valid (order 0), channel 1 zero. After 1 arrives, the next emit is orders 1,2 on channels 0,1.
- Reset mid-operation: 4 records buffered, reset pulsed for one cycle -> pending=0, rvfi_valid=0, halted=0. Next accept of order 0 is emitted normally; old records never appear.

Source files
------------

// File: rtl/rvfi_retire_serializer.sv
// Reorders out-of-order retire records by order number and emits in-order RVFI
// packets on NRET channels; stops emitting for good once a halt record retires.
module rvfi_retire_serializer #(
    parameter int NRET  = 1,
    parameter int ILEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [63:0]               in_order,
    input  logic [ILEN-1:0]           in_insn,
    input  logic                      in_trap,
    input  logic                      in_halt,
    output logic [NRET-1:0]           rvfi_valid,
    output logic [NRET*64-1:0]        rvfi_order,
    output logic [NRET*ILEN-1:0]      rvfi_insn,
    output logic [NRET-1:0]           rvfi_trap,
    output logic [NRET-1:0]           rvfi_halt,
    output logic [$clog2(DEPTH):0]    pending,
    output logic                      halted
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int KW = $clog2(NRET + 1);

    typedef enum logic {RUN, HALTED} state_t;

    state_t                        state_q, state_d;
    logic [63:0]                   head_q, head_d;
    logic [DEPTH-1:0]              occ_q, occ_d;
    logic [DEPTH-1:0][ILEN-1:0]    slot_insn_q, slot_insn_d;
    logic [DEPTH-1:0]              slot_trap_q, slot_trap_d;
    logic [DEPTH-1:0]              slot_halt_q, slot_halt_d;
    logic [PW-1:0]                 pending_q, pending_d;

    logic [NRET-1:0]               valid_q, valid_d;
    logic [NRET*64-1:0]            order_q, order_d;
    logic [NRET*ILEN-1:0]          insn_q, insn_d;
    logic [NRET-1:0]               trap_q, trap_d;
    logic [NRET-1:0]               halt_q, halt_d;

    logic [AW-1:0]                 in_idx;
    logic [63:0]                   in_dist;
    logic                          accept;
    logic [AW-1:0]                 slot;
    logic                          cont;
    logic                          emit_halt;
    logic [KW-1:0]                 emit_cnt;

    // Unsigned distance: orders behind head wrap to huge values and are refused.
    assign in_idx   = in_order[AW-1:0];
    assign in_dist  = in_order - head_q;
    assign in_ready = !reset && (state_q == RUN) && (in_dist < 64'(DEPTH)) && !occ_q[in_idx];
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        occ_d       = occ_q;
        slot_insn_d = slot_insn_q;
        slot_trap_d = slot_trap_q;
        slot_halt_d = slot_halt_q;
        valid_d     = '0;
        order_d     = '0;
        insn_d      = '0;
        trap_d      = '0;
        halt_d      = '0;
        slot        = head_q[AW-1:0];
        cont        = 1'b1;
        emit_halt   = 1'b0;
        emit_cnt    = '0;

        if (state_q == RUN) begin
            // Emit the contiguous occupied run at head, ending at a halt record.
            for (int c = 0; c < NRET; c++) begin
                slot = head_q[AW-1:0] + AW'(c);
                if (cont && (c < DEPTH) && occ_q[slot]) begin
                    valid_d[c]               = 1'b1;
                    order_d[c*64 +: 64]      = head_q + 64'(c);
                    insn_d[c*ILEN +: ILEN]   = slot_insn_q[slot];
                    trap_d[c]                = slot_trap_q[slot];
                    halt_d[c]                = slot_halt_q[slot];
                    occ_d[slot]              = 1'b0;
                    emit_cnt                 = emit_cnt + KW'(1);
                    if (slot_halt_q[slot]) begin
                        cont      = 1'b0;
                        emit_halt = 1'b1;
                    end
                end else begin
                    cont = 1'b0;
                end
            end
            head_d = head_q + 64'(emit_cnt);
            if (emit_halt) state_d = HALTED;
        end

        // An accepted slot is unoccupied, so it never collides with an emitted one.
        if (accept) begin
            occ_d[in_idx]       = 1'b1;
            slot_insn_d[in_idx] = in_insn;
            slot_trap_d[in_idx] = in_trap;
            slot_halt_d[in_idx] = in_halt;
        end

        pending_d = pending_q + PW'(accept) - PW'(emit_cnt);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= RUN;
            head_q    <= '0;
            occ_q     <= '0;
            pending_q <= '0;
            valid_q   <= '0;
            order_q   <= '0;
            insn_q    <= '0;
            trap_q    <= '0;
            halt_q    <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            occ_q       <= occ_d;
            pending_q   <= pending_d;
            slot_insn_q <= slot_insn_d;
            slot_trap_q <= slot_trap_d;
            slot_halt_q <= slot_halt_d;
            valid_q     <= valid_d;
            order_q     <= order_d;
            insn_q      <= insn_d;
            trap_q      <= trap_d;
            halt_q      <= halt_d;
        end
    end

    assign rvfi_valid = valid_q;
    assign rvfi_order = order_q;
    assign rvfi_insn  = insn_q;
    assign rvfi_trap  = trap_q;
    assign rvfi_halt  = halt_q;
    assign pending    = pending_q;
    assign halted     = (state_q == HALTED);
endmodule

// File: tb/tb_rvfi_retire_serializer.sv
// Directed plus random stimulus for rvfi_retire_serializer (NRET=2, DEPTH=8),
// checked every cycle against a map-based model of buffered records.
module tb_rvfi_retire_serializer;
    localparam int NRET  = 2;
    localparam int ILEN  = 32;
    localparam int DEPTH = 8;

    logic                    clock, reset;
    logic                    in_valid, in_ready;
    logic [63:0]             in_order;
    logic [ILEN-1:0]         in_insn;
    logic                    in_trap, in_halt;
    logic [NRET-1:0]         rvfi_valid, rvfi_trap, rvfi_halt;
    logic [NRET*64-1:0]      rvfi_order;
    logic [NRET*ILEN-1:0]    rvfi_insn;
    logic [$clog2(DEPTH):0]  pending;
    logic                    halted;

    rvfi_retire_serializer #(.NRET(NRET), .ILEN(ILEN), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_order(in_order),
        .in_insn(in_insn), .in_trap(in_trap), .in_halt(in_halt),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
        .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt),
        .pending(pending), .halted(halted)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [ILEN-1:0] insn;
        logic            trap;
        logic            halt;
    } rec_t;

    // Model: buffered records keyed by full order number.
    rec_t                 m_buf [logic [63:0]];
    logic [63:0]          m_head;
    bit                   m_halted;
    logic [NRET-1:0]      e_valid, e_trap, e_halt;
    logic [NRET*64-1:0]   e_order;
    logic [NRET*ILEN-1:0] e_insn;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit acc, input logic [63:0] o, input logic [ILEN-1:0] i,
                              input bit t, input bit h);
        rec_t        r;
        bit          stop;
        logic [63:0] key;
        e_valid = '0; e_order = '0; e_insn = '0; e_trap = '0; e_halt = '0;
        if (reset) begin
            m_buf.delete();
            m_head   = '0;
            m_halted = 0;
            return;
        end
        if (m_halted) return;
        stop = 0;
        for (int c = 0; c < NRET; c++) begin
            key = m_head + 64'(c);
            if (!stop && m_buf.exists(key)) begin
                r = m_buf[key];
                e_valid[c]             = 1'b1;
                e_order[c*64 +: 64]    = key;
                e_insn[c*ILEN +: ILEN] = r.insn;
                e_trap[c]              = r.trap;
                e_halt[c]              = r.halt;
                m_buf.delete(key);
                if (r.halt) begin
                    stop     = 1;
                    m_halted = 1;
                end
            end else begin
                stop = 1;
            end
        end
        m_head = m_head + 64'($countones(e_valid));
        if (acc) m_buf[o] = '{insn: i, trap: t, halt: h};
    endtask

    task automatic check_outputs();
        chk("rvfi_valid", 128'(rvfi_valid), 128'(e_valid));
        chk("rvfi_order", 128'(rvfi_order), 128'(e_order));
        chk("rvfi_insn",  128'(rvfi_insn),  128'(e_insn));
        chk("rvfi_trap",  128'(rvfi_trap),  128'(e_trap));
        chk("rvfi_halt",  128'(rvfi_halt),  128'(e_halt));
        chk("pending",    128'(pending),    128'(m_buf.num()));
        chk("halted",     128'(halted),     128'(m_halted));
    endtask

    task automatic step(input bit v, input logic [63:0] o, input logic [ILEN-1:0] i,
                        input bit t, input bit h);
        bit exp_rdy;
        in_valid = v; in_order = o; in_insn = i; in_trap = t; in_halt = h;
        #1;
        exp_rdy = !reset && !m_halted && ((o - m_head) < 64'(DEPTH)) && !m_buf.exists(o);
        chk("in_ready", 128'(in_ready), 128'(exp_rdy));
        @(posedge clock);
        model_edge(v && exp_rdy, o, i, t, h);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(0, 64'd0, '0, 0, 0);
    endtask

    logic [63:0] ro;

    initial begin
        clock = 0; reset = 1;
        in_valid = 0; in_order = '0; in_insn = '0; in_trap = 0; in_halt = 0;
        m_head = '0; m_halted = 0;
        e_valid = '0; e_order = '0; e_insn = '0; e_trap = '0; e_halt = '0;
        @(posedge clock); #1;

        // reset state
        idle(2);
        reset = 0;

        // in-order stream
        step(1, 64'd0, 32'h13, 0, 0);
        chk("inorder_first_not_yet", 128'(rvfi_valid), 128'd0);
        step(1, 64'd1, 32'h93, 0, 0);
        step(1, 64'd2, 32'h113, 0, 0);
        idle(2);

        // out-of-order arrival (head is now 3)
        step(1, 64'd5, 32'h500, 0, 0);
        step(1, 64'd4, 32'h400, 1, 0);
        chk("ooo_pending2", 128'(pending), 128'd2);
        step(1, 64'd3, 32'h300, 0, 0);
        idle(4);

        // window limit (head is now 6)
        step(1, 64'd14, 32'hE, 0, 0);
        chk("win_head_plus_depth", 128'(in_ready), 128'd0);
        step(1, 64'd13, 32'hD, 0, 0);
        step(1, 64'd9, 32'h9, 0, 0);
        step(1, 64'd9, 32'h99, 0, 0);
        step(1, 64'd5, 32'h5, 0, 0);
        reset = 1; idle(1); reset = 0;

        // multi-channel truncation
        step(1, 64'd2, 32'h222, 0, 0);
        step(1, 64'd0, 32'h000, 0, 0);
        step(1, 64'd1, 32'h111, 0, 0);
        chk("trunc_ch1_zero", 128'(rvfi_valid), 128'b01);
        idle(1);
        chk("trunc_both", 128'(rvfi_valid), 128'b11);
        idle(1);

        // halt (head is now 3)
        reset = 1; idle(1); reset = 0;
        step(1, 64'd2, 32'h2, 0, 0);
        step(1, 64'd1, 32'h1, 0, 1);
        step(1, 64'd0, 32'h0, 0, 0);
        idle(1);
        chk("halt_flag", 128'(halted), 128'd1);
        chk("halt_ch1", 128'(rvfi_halt), 128'b10);
        for (int j = 0; j < 20; j++) step(1, 64'd3, 32'h3, 0, 0);
        chk("halt_pending_frozen", 128'(pending), 128'd1);

        // reset mid-operation
        reset = 1; idle(1); reset = 0;
        for (int j = 1; j <= 4; j++) step(1, 64'(j), 32'(j * 16), 0, 0);
        reset = 1; idle(1); reset = 0;
        chk("rst_pending", 128'(pending), 128'd0);
        step(1, 64'd0, 32'hABC, 0, 0);
        idle(3);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            if (m_halted) reset = ($urandom_range(0, 5) == 0);
            else reset = ($urandom_range(0, 149) == 0);
            ro = m_head + 64'($urandom_range(0, DEPTH + 2));
            if ($urandom_range(0, 9) == 0) ro = ro - 64'd3;
            step($urandom_range(0, 3) != 0, ro, $urandom,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0);
            reset = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
